loader_mem_arbiter: RTL and testbench
=====================================

// Module: loader_mem_arbiter
// PURPOSE
//  Shares the single cartridge-memory port (PRG at 0x000000, CHR at 0x200000, 22-bit byte address) between the ROM loader write stream and the NES core.
//  Loader writes are single-cycle strobes with no backpressure, so they enter a small FIFO.
//  The FIFO is then drained via a req/ack memory handshake, interleaved with core requests under a fixed-priority scheme with a starvation guard.
//  Sits between the iNES loader / core memory clients and the memory controller.
// PARAMETERS
//  FIFO_AW   3  log2 of loader FIFO depth (8 entries of {addr[21:0],data[7:0]})
//  LD_BURST  4  max consecutive loader grants while core_req is pending (1..255)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  ld_addr      in   22  loader write address
//  ld_data      in   8   loader write data
//  ld_write     in   1   one-cycle write strobe; push {ld_addr,ld_data}
//  ld_overflow  out  1   sticky: a push was dropped (FIFO full)
//  ld_drained   out  1   FIFO empty and no loader transfer in flight
//  fifo_level   out  FIFO_AW+1  current FIFO occupancy
//  core_req     in   1   core request; held high until core_ack
//  core_addr    in   22  core address (stable while core_req)
//  core_we      in   1   1=write, 0=read
//  core_wdata   in   8   core write data
//  core_ack     out  1   one-cycle completion pulse
//  core_rdata   out  8   read data; valid in the core_ack cycle, held until the next core read completes
//  mem_req      out  1   request to memory controller; held until mem_ack
//  mem_addr     out  22  request address
//  mem_we       out  1   request direction
//  mem_wdata    out  8   request write data
//  mem_ack      in   1   one-cycle completion from memory controller
//  mem_rdata    in   8   read data; valid with mem_ack
//  ld_checksum  out  16  see CONFIGURATION
// BEHAVIOUR
//  Reset values: all outputs 0 except ld_drained=1; FIFO empty; burst_cnt=0; state IDLE.
//  FIFO behaviour:
//   - Push on ld_write.
//   - If full with no pop in the same cycle, the entry is dropped and ld_overflow is set; it clears only on reset.
//   - A push and a pop in the same cycle while full are both accepted.
//   - A pop only takes an entry present before the edge; there is no fall-through.
//  State machine: IDLE, LD_XFER, CORE_XFER.
//  IDLE:
//   - If the FIFO is non-empty and (!core_req or burst_cnt<LD_BURST): pop the head, go to LD_XFER.
//   - Else if core_req: go to CORE_XFER.
//   - mem_req rises on the edge that enters an XFER state, together with mem_addr, mem_we and mem_wdata.
//   - For LD_XFER, mem_we=1.
//   - These signals stay stable until mem_ack.
//  LD_XFER:
//   - On mem_ack: mem_req=0 on the next edge, return to IDLE.
//   - burst_cnt+1 if core_req is high, else burst_cnt=0. Saturating 8-bit.
//  CORE_XFER:
//   - On mem_ack: mem_req=0, core_ack=1 for exactly one cycle on the next edge, return to IDLE, burst_cnt=0.
//   - On a read, core_rdata is registered from mem_rdata.
//  Minimum turnaround: one IDLE cycle between transactions, so back-to-back grants are 2 clk + memory latency apart.
//  core_req falling before core_ack is illegal; the request in flight still completes and the ack is still pulsed.
//  mem_ack outside an XFER state is ignored.
//  ld_drained = (fifo_level==0) && state!=LD_XFER; combinational from registers.
//  Reset in mid-transaction: mem_req drops on that edge and the transaction is abandoned. The memory controller is reset by the same signal.
// CONFIGURATION
//  LDARB_CHECKSUM_EN defined:
//   - ld_checksum is a 16-bit wrap-around sum of mem_wdata over completed LD_XFER transactions (updated on mem_ack).
//   - Cleared by reset.
//  LDARB_CHECKSUM_EN undefined: ld_checksum tied to 0 and no adder is built.
// TESTING
//  - Loader only: 3 strobes 0x000000/AA, 0x000001/BB, 0x200000/CC, mem_ack 2 clk after each mem_req -> three writes in order, ld_drained=1 after the last ack, checksum 0x0231 when enabled.
//  - Overflow: 9 consecutive strobes, mem_ack held low -> fifo_level=8, ld_overflow=1, 9th entry absent from the memory sequence.
//  - Starvation guard: FIFO holds 8 entries and core_req is high (read 0x000010, mem_rdata=5A) -> exactly 4 loader writes, then the core read, core_ack pulse with core_rdata=5A, then the remaining 4 loader writes.
//  - Core only: write 0x200123/7E, then read -> one core_ack per request, one cycle wide, mem_we 1 then 0.
//  - Simultaneous push/pop at full: push in the cycle IDLE pops -> fifo_level stays 8, ld_overflow stays 0.
//  - Reset during LD_XFER with mem_req high -> next cycle mem_req=0, fifo_level=0, ld_drained=1, ld_overflow=0.

Source files
------------

// File: rtl/loader_mem_arbiter_if.sv
// loader_mem_arbiter_if: loader, core and memory-controller signal bundle for loader_mem_arbiter
interface loader_mem_arbiter_if #(parameter int FIFO_AW = 3);
    logic [21:0]      ld_addr;
    logic [7:0]       ld_data;
    logic             ld_write;
    logic             ld_overflow;
    logic             ld_drained;
    logic [FIFO_AW:0] fifo_level;
    logic             core_req;
    logic [21:0]      core_addr;
    logic             core_we;
    logic [7:0]       core_wdata;
    logic             core_ack;
    logic [7:0]       core_rdata;
    logic             mem_req;
    logic [21:0]      mem_addr;
    logic             mem_we;
    logic [7:0]       mem_wdata;
    logic             mem_ack;
    logic [7:0]       mem_rdata;
    logic [15:0]      ld_checksum;
    modport slave (
        input  ld_addr, ld_data, ld_write, core_req, core_addr, core_we, core_wdata, mem_ack, mem_rdata,
        output ld_overflow, ld_drained, fifo_level, core_ack, core_rdata, mem_req, mem_addr, mem_we,
               mem_wdata, ld_checksum
    );
    modport master (
        output ld_addr, ld_data, ld_write, core_req, core_addr, core_we, core_wdata, mem_ack, mem_rdata,
        input  ld_overflow, ld_drained, fifo_level, core_ack, core_rdata, mem_req, mem_addr, mem_we,
               mem_wdata, ld_checksum
    );
endinterface

// File: rtl/loader_mem_arbiter.sv
// loader_mem_arbiter: loader write FIFO and core requests share one memory port; LDARB_CHECKSUM_EN enables ld_checksum
module loader_mem_arbiter #(
    parameter int FIFO_AW  = 3,
    parameter int LD_BURST = 4
) (
    input logic clk,
    input logic reset,
    loader_mem_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, LD_XFER, CORE_XFER} state_t;
    state_t state, state_d;
    logic [29:0] fifo [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] count;
    logic [7:0] burst_cnt, burst_d;
    logic mem_req, mem_req_d, mem_we, mem_we_d, core_ack, core_ack_d, overflow;
    logic [21:0] mem_addr, mem_addr_d;
    logic [7:0] mem_wdata, mem_wdata_d, core_rdata, core_rdata_d;
    logic pop, push, full;
    // occupancy never exceeds DEPTH, so its MSB alone flags full
    assign full = count[FIFO_AW];
    assign push = bus.ld_write && (!full || pop);
    always_comb begin
        state_d = state;
        mem_req_d = mem_req;
        mem_addr_d = mem_addr;
        mem_we_d = mem_we;
        mem_wdata_d = mem_wdata;
        core_ack_d = 1'b0;
        core_rdata_d = core_rdata;
        burst_d = burst_cnt;
        pop = 1'b0;
        case (state)
            IDLE:
                if (count != '0 && (!bus.core_req || burst_cnt < 8'(LD_BURST))) begin
                    pop = 1'b1;
                    state_d = LD_XFER;
                    mem_req_d = 1'b1;
                    mem_we_d = 1'b1;
                    {mem_addr_d, mem_wdata_d} = fifo[rd_ptr];
                end else if (bus.core_req) begin
                    state_d = CORE_XFER;
                    mem_req_d = 1'b1;
                    mem_we_d = bus.core_we;
                    mem_addr_d = bus.core_addr;
                    mem_wdata_d = bus.core_wdata;
                end
            LD_XFER:
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    mem_req_d = 1'b0;
                    burst_d = !bus.core_req ? 8'd0 : burst_cnt == 8'hff ? burst_cnt : burst_cnt + 8'd1;
                end
            CORE_XFER:
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    mem_req_d = 1'b0;
                    core_ack_d = 1'b1;
                    burst_d = 8'd0;
                    core_rdata_d = mem_we ? core_rdata : bus.mem_rdata;
                end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_addr <= '0;
            mem_we <= 1'b0;
            mem_wdata <= '0;
            core_ack <= 1'b0;
            core_rdata <= '0;
            burst_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_d;
            mem_req <= mem_req_d;
            mem_addr <= mem_addr_d;
            mem_we <= mem_we_d;
            mem_wdata <= mem_wdata_d;
            core_ack <= core_ack_d;
            core_rdata <= core_rdata_d;
            burst_cnt <= burst_d;
            wr_ptr <= wr_ptr + FIFO_AW'(push);
            rd_ptr <= rd_ptr + FIFO_AW'(pop);
            count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            overflow <= overflow || (bus.ld_write && !push);
        end
    end
    always_ff @(posedge clk) if (push) fifo[wr_ptr] <= {bus.ld_addr, bus.ld_data};
`ifdef LDARB_CHECKSUM_EN
    logic [15:0] checksum;
    always_ff @(posedge clk) begin
        if (reset) checksum <= '0;
        else if (state == LD_XFER && bus.mem_ack) checksum <= checksum + {8'd0, mem_wdata};
    end
    assign bus.ld_checksum = checksum;
`else
    assign bus.ld_checksum = 16'd0;
`endif
    assign bus.mem_req = mem_req;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_we = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.core_ack = core_ack;
    assign bus.core_rdata = core_rdata;
    assign bus.fifo_level = count;
    assign bus.ld_overflow = overflow;
    assign bus.ld_drained = count == '0 && state != LD_XFER;
endmodule

// File: tb/tb_loader_mem_arbiter.sv
// tb_loader_mem_arbiter: scoreboard bench for loader_mem_arbiter with a memory-controller model
module tb_loader_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    loader_mem_arbiter_if #(.FIFO_AW(3)) bus();
    loader_mem_arbiter #(.FIFO_AW(3), .LD_BURST(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`ifdef LDARB_CHECKSUM_EN
    localparam logic [15:0] EXP_CK = 16'h0231;
`else
    localparam logic [15:0] EXP_CK = 16'h0000;
`endif
    int errors = 0;
    int checks = 0;
    int cnt = 0;
    int lat = 2;
    logic ack_en = 1'b1;
    logic prev_ack = 1'b0;
    logic [7:0] rd_val = 8'h5A;
    logic [30:0] exp_q[$];

    // one clock: memory model answers after lat cycles and checks each transaction against the scoreboard
    task automatic step();
        logic [30:0] e;
        @(negedge clk);
        if (bus.core_ack) begin
            checks++;
            if (prev_ack) begin
                errors++;
                $display("FAIL core_ack_width: core_ack high 2+ cycles, required 1");
            end
        end
        prev_ack = bus.core_ack;
        if (bus.mem_ack) bus.mem_ack = 1'b0;
        else if (!bus.mem_req) cnt = 0;
        else if (ack_en) begin
            cnt++;
            if (cnt >= lat) begin
                cnt = 0;
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd_val;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_seq: got we/addr/data %h, required no transaction",
                             {bus.mem_we, bus.mem_addr, bus.mem_wdata});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL mem_seq: got we/addr/data %h, required %h",
                                 {bus.mem_we, bus.mem_addr, bus.mem_wdata}, e);
                    end
                end
            end
        end
    endtask

    function automatic void expect_mem(input logic we, input logic [21:0] a, input logic [7:0] d);
        exp_q.push_back({we, a, d});
    endfunction

    task automatic push_ld(input logic [21:0] a, input logic [7:0] d);
        bus.ld_addr = a;
        bus.ld_data = d;
        bus.ld_write = 1'b1;
        step();
        bus.ld_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cnt = 0;
        bus.mem_ack = 1'b0;
        prev_ack = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_core_ack(input string name);
        for (int i = 0; i < 100 && !bus.core_ack; i++) step();
        checks++;
        if (!bus.core_ack) begin
            errors++;
            $display("FAIL %s: core_ack=0 after 100 cycles, required 1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && !(exp_q.size() == 0 && bus.ld_drained && !bus.mem_req); i++) step();
        checks++;
        if (!(exp_q.size() == 0 && bus.ld_drained && !bus.mem_req)) begin
            errors++;
            $display("FAIL %s: pending=%0d drained=%b mem_req=%b, required 0/1/0",
                     name, exp_q.size(), bus.ld_drained, bus.mem_req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b, required 0", bus.mem_req); end
        if (bus.core_ack !== 1'b0) begin errors++; $display("FAIL reset_core_ack: got %b, required 0", bus.core_ack); end
        if (bus.ld_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", bus.ld_overflow); end
        if (bus.ld_drained !== 1'b1) begin errors++; $display("FAIL reset_drained: got %b, required 1", bus.ld_drained); end
        if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", bus.fifo_level); end
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.core_rdata, bus.ld_checksum} !== 55'd0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h we=%b wdata=%h rdata=%h ck=%h, required all 0",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.core_rdata, bus.ld_checksum);
        end
    endtask

    task automatic test_loader_only();
        do_reset();
        expect_mem(1'b1, 22'h000000, 8'hAA);
        expect_mem(1'b1, 22'h000001, 8'hBB);
        expect_mem(1'b1, 22'h200000, 8'hCC);
        push_ld(22'h000000, 8'hAA);
        push_ld(22'h000001, 8'hBB);
        push_ld(22'h200000, 8'hCC);
        wait_idle("loader_only_drain");
        checks += 2;
        if (bus.ld_drained !== 1'b1) begin errors++; $display("FAIL loader_drained: got %b, required 1", bus.ld_drained); end
        if (bus.ld_checksum !== EXP_CK) begin errors++; $display("FAIL loader_checksum: got %h, required %h", bus.ld_checksum, EXP_CK); end
    endtask

    task automatic test_core_only();
        rd_val = 8'h3C;
        bus.core_addr = 22'h200123;
        bus.core_we = 1'b1;
        bus.core_wdata = 8'h7E;
        bus.core_req = 1'b1;
        expect_mem(1'b1, 22'h200123, 8'h7E);
        wait_core_ack("core_write_ack");
        checks++;
        if (bus.core_rdata !== 8'h00) begin errors++; $display("FAIL core_write_rdata: got %h, required 00", bus.core_rdata); end
        bus.core_req = 1'b0;
        step();
        checks++;
        if (bus.core_ack !== 1'b0) begin errors++; $display("FAIL core_write_pulse: got %b, required 0", bus.core_ack); end
        bus.core_addr = 22'h000050;
        bus.core_we = 1'b0;
        bus.core_req = 1'b1;
        expect_mem(1'b0, 22'h000050, 8'h7E);
        wait_core_ack("core_read_ack");
        checks++;
        if (bus.core_rdata !== 8'h3C) begin errors++; $display("FAIL core_read_rdata: got %h, required 3C", bus.core_rdata); end
        bus.core_req = 1'b0;
        step();
        checks += 2;
        if (bus.core_ack !== 1'b0) begin errors++; $display("FAIL core_read_pulse: got %b, required 0", bus.core_ack); end
        if (bus.core_rdata !== 8'h3C) begin errors++; $display("FAIL core_rdata_hold: got %h, required 3C", bus.core_rdata); end
        wait_idle("core_only_idle");
    endtask

    task automatic test_overflow();
        ack_en = 1'b0;
        bus.core_addr = 22'h000100;
        bus.core_we = 1'b1;
        bus.core_wdata = 8'h11;
        bus.core_req = 1'b1;
        expect_mem(1'b1, 22'h000100, 8'h11);
        step();
        step();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_mem(1'b1, 22'h000020 + 22'(i), 8'h20 + 8'(i));
            push_ld(22'h000020 + 22'(i), 8'h20 + 8'(i));
        end
        checks += 3;
        if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL overflow_level: got %0d, required 8", bus.fifo_level); end
        if (bus.ld_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b, required 1", bus.ld_overflow); end
        if (bus.ld_drained !== 1'b0) begin errors++; $display("FAIL overflow_drained: got %b, required 0", bus.ld_drained); end
        ack_en = 1'b1;
        wait_core_ack("overflow_core_ack");
        bus.core_req = 1'b0;
        wait_idle("overflow_drain");
        checks++;
        if (bus.ld_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b, required 1", bus.ld_overflow); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        ack_en = 1'b0;
        bus.core_addr = 22'h000200;
        bus.core_we = 1'b1;
        bus.core_wdata = 8'h22;
        bus.core_req = 1'b1;
        expect_mem(1'b1, 22'h000200, 8'h22);
        for (int i = 0; i < 9; i++) expect_mem(1'b1, 22'h000300 + 22'(i), 8'h40 + 8'(i));
        step();
        step();
        for (int i = 0; i < 8; i++) push_ld(22'h000300 + 22'(i), 8'h40 + 8'(i));
        checks++;
        if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL pp_full_level: got %0d, required 8", bus.fifo_level); end
        ack_en = 1'b1;
        wait_core_ack("pp_core_ack");
        bus.core_req = 1'b0;
        push_ld(22'h000308, 8'h48);
        checks += 3;
        if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL pp_level: got %0d, required 8", bus.fifo_level); end
        if (bus.ld_overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b, required 0", bus.ld_overflow); end
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL pp_mem_req: got %b, required 1", bus.mem_req); end
        wait_idle("pp_drain");
    endtask

    task automatic test_starvation();
        rd_val = 8'h5A;
        ack_en = 1'b0;
        bus.core_addr = 22'h000400;
        bus.core_we = 1'b1;
        bus.core_wdata = 8'h33;
        bus.core_req = 1'b1;
        expect_mem(1'b1, 22'h000400, 8'h33);
        for (int i = 0; i < 8; i++) begin
            expect_mem(1'b1, 22'h000500 + 22'(i), 8'h60 + 8'(i));
            if (i == 3) expect_mem(1'b0, 22'h000010, 8'h00);
        end
        step();
        step();
        for (int i = 0; i < 8; i++) push_ld(22'h000500 + 22'(i), 8'h60 + 8'(i));
        checks++;
        if (bus.fifo_level !== 4'd8) begin errors++; $display("FAIL starve_level: got %0d, required 8", bus.fifo_level); end
        ack_en = 1'b1;
        wait_core_ack("starve_first_ack");
        bus.core_addr = 22'h000010;
        bus.core_we = 1'b0;
        bus.core_wdata = 8'h00;
        step();
        wait_core_ack("starve_read_ack");
        checks++;
        if (bus.core_rdata !== 8'h5A) begin errors++; $display("FAIL starve_rdata: got %h, required 5A", bus.core_rdata); end
        bus.core_req = 1'b0;
        wait_idle("starve_drain");
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b0;
        push_ld(22'h000000, 8'h99);
        push_ld(22'h000001, 8'h98);
        step();
        checks += 2;
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req_before: got %b, required 1", bus.mem_req); end
        if (bus.fifo_level !== 4'd1) begin errors++; $display("FAIL mid_level_before: got %0d, required 1", bus.fifo_level); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 4;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_mem_req: got %b, required 0", bus.mem_req); end
        if (bus.fifo_level !== 4'd0) begin errors++; $display("FAIL mid_level: got %0d, required 0", bus.fifo_level); end
        if (bus.ld_drained !== 1'b1) begin errors++; $display("FAIL mid_drained: got %b, required 1", bus.ld_drained); end
        if (bus.ld_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b, required 0", bus.ld_overflow); end
        ack_en = 1'b1;
        cnt = 0;
        exp_q.delete();
    endtask

    initial begin
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.ld_write = 1'b0;
        bus.core_req = 1'b0;
        bus.core_addr = '0;
        bus.core_we = 1'b0;
        bus.core_wdata = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_loader_only();
        test_core_only();
        test_overflow();
        test_push_pop_full();
        test_starvation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
